ternary_neuron_acc: RTL and testbench
=====================================

TERNARY_NEURON_ACC -- requirements
Module: ternary_neuron_acc

Interface
REQ-001 Parameter ACC_W, default 10: signed accumulator and out_sum width, legal range 7..16.
REQ-002 Parameter MAX_BEATS, default 16: maximum beats per neuron evaluation, legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream beat valid.
REQ-006 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 Port pos_cnt, input, 5: unsigned popcount of the positive-weight 27-input group, 0..31.
REQ-008 Port neg_cnt, input, 5: unsigned popcount of the negative-weight 27-input group, 0..31.
REQ-009 Port in_last, input, 1: final beat of the current neuron evaluation.
REQ-010 Port thr_hi, input, ACC_W: signed upper threshold; quasi-static.
REQ-011 Port thr_lo, input, ACC_W: signed lower threshold; quasi-static.
REQ-012 Port out_valid, output, 1: result valid.
REQ-013 Port out_ready, input, 1: downstream accepts the result.
REQ-014 Port out_act, output, 2: ternary activation; 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
REQ-015 Port out_sum, output, ACC_W: signed final accumulated sum.
REQ-016 Port out_sat, output, 1: saturation occurred in this evaluation.
REQ-017 Port out_err, output, 1: beat count exceeded MAX_BEATS in this evaluation.

Function
REQ-018 States SHALL be IDLE, ACCUM and HOLD.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-020 A beat is accepted when in_valid and in_ready are both 1.
REQ-021 Each accepted beat SHALL add the 6-bit signed difference d = pos_cnt - neg_cnt (range -31..31) to acc.
REQ-022 The addition SHALL saturate to the signed ACC_W range; on clipping, a sticky sat flag SHALL be set.
REQ-023 Transition IDLE->ACCUM SHALL occur on an accepted beat with in_last = 0.
REQ-024 Transition IDLE->HOLD or ACCUM->HOLD SHALL occur on an accepted beat with in_last = 1.
REQ-025 A single-beat evaluation (first beat has in_last = 1) SHALL be legal.
REQ-026 The 8-bit beat counter SHALL increment per accepted beat.
REQ-027 When the counter reaches MAX_BEATS without in_last, the next accepted beat SHALL set a sticky err flag; accumulation SHALL continue and the counter SHALL saturate at 255.
REQ-028 out_valid SHALL assert the cycle after the last beat is accepted (latency 1).
REQ-029 out_sum, out_act, out_sat and out_err SHALL be registered and held stable while out_valid = 1.
REQ-030 out_act SHALL be +1 if sum > thr_hi, -1 if sum < thr_lo, else 0.
REQ-031 If thr_lo > thr_hi and both comparisons hold, +1 SHALL take priority.
REQ-032 Thresholds SHALL be sampled in the cycle the last beat is accepted.
REQ-033 HOLD->IDLE SHALL occur on out_valid and out_ready; in the same cycle acc, counter, sat and err SHALL clear and out_valid SHALL drop.
REQ-034 in_ready SHALL rise in the cycle after the output handshake (one bubble per evaluation, by design).
REQ-035 in_valid with in_ready = 0 SHALL be ignored without side effects.
REQ-036 Outputs SHALL not depend combinationally on in_valid, pos_cnt or neg_cnt.

Reset
REQ-037 rst SHALL force state IDLE; acc, counter, sat and err to 0; out_valid, out_sat and out_err to 0; out_sum to 0; out_act to 2'b00; in_ready to 1 in the following cycle.
REQ-038 rst asserted mid-evaluation or in HOLD SHALL discard the partial or pending result with no output handshake.
REQ-039 rst SHALL take priority over all simultaneous events.

Structure
REQ-040 Shared package ternary_pkg SHALL hold the state enum, the activation encodings ACT_POS, ACT_NEG and ACT_ZERO, and the popcount width constant PC_W = 5.
REQ-041 The saturating signed adder SHALL be the single sub-module sat_add_s, parameterised by width, with a clip flag output.

Verification
REQ-042 Single-beat test: ACC_W = 10, thr_hi = 3, thr_lo = -3; beat pos = 20, neg = 5, last -> one cycle later out_valid, out_sum = 15, out_act = 01, out_sat = 0.
REQ-043 Three-beat test: beats (2,9), (0,27), (4,1), last on beat 3 -> out_sum = -31, out_act = 11; out_valid held 4 cycles under out_ready = 0, outputs stable.
REQ-044 Saturation test: ACC_W = 7; 5 beats of (31,0) -> out_sum = 63, out_sat = 1, out_act = 01; the next evaluation (1,1) gives out_sat = 0, out_sum = 0, out_act = 00.
REQ-045 Overflow test: MAX_BEATS = 2; 3 beats (1,0), last on beat 3 -> out_err = 1, out_sum = 3.
REQ-046 Back-pressure and reset test: in_valid held high during HOLD -> no beat absorbed; rst pulsed after 2 of 4 beats -> no out_valid; the fresh 1-beat evaluation (3,3) gives out_sum = 0.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary neuron accumulator.
// Holds the FSM states, the activation encodings and the popcount width.
package ternary_pkg;

    localparam int PC_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    // +1 wins over -1 when an inverted threshold pair makes both comparisons true
    function automatic logic [1:0] act_encode(input logic gt_hi, input logic lt_lo);
        logic [1:0] act;
        if (gt_hi) begin
            act = ACT_POS;
        end else if (lt_lo) begin
            act = ACT_NEG;
        end else begin
            act = ACT_ZERO;
        end
        return act;
    endfunction

endpackage

// File: rtl/ternary_neuron_acc_if.sv
// Beat-in / result-out bus of the ternary neuron accumulator.
// The slave modport is the accumulator's view, the master modport the driver's.
interface ternary_neuron_acc_if #(
    parameter int ACC_W = 10
) ();
    import ternary_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [PC_W-1:0]         pos_cnt;
    logic [PC_W-1:0]         neg_cnt;
    logic                    in_last;
    logic signed [ACC_W-1:0] thr_hi;
    logic signed [ACC_W-1:0] thr_lo;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_act;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_sat;
    logic                    out_err;

    modport slave (
        input  in_valid, pos_cnt, neg_cnt, in_last, thr_hi, thr_lo, out_ready,
        output in_ready, out_valid, out_act, out_sum, out_sat, out_err
    );

    modport master (
        output in_valid, pos_cnt, neg_cnt, in_last, thr_hi, thr_lo, out_ready,
        input  in_ready, out_valid, out_act, out_sum, out_sat, out_err
    );
endinterface

// File: rtl/ternary_neuron_acc_sat_add.sv
// Signed adder that clips to the W-bit two's-complement range.
// o_clip flags that the true sum did not fit and was clamped.
module sat_add_s #(
    parameter int W = 10
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_sum,
    output logic                o_clip
);
    logic [W:0]   w_full;
    logic [W-1:0] w_max;
    logic [W-1:0] w_min;

    assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    assign w_max  = {1'b0, {(W-1){1'b1}}};
    assign w_min  = {1'b1, {(W-1){1'b0}}};

    // Overflow shows up as disagreement between the extra sign bit and the MSB
    always_comb begin
        o_clip = w_full[W] ^ w_full[W-1];
        if (o_clip) begin
            o_sum = w_full[W] ? w_min : w_max;
        end else begin
            o_sum = w_full[W-1:0];
        end
    end
endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulates signed popcount differences over a multi-beat evaluation,
// then presents a held, thresholded ternary activation until accepted.
module ternary_neuron_acc
    import ternary_pkg::*;
#(
    parameter int ACC_W     = 10,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    ternary_neuron_acc_if.slave bus
);
    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_t r_state;
    state_t w_next_state;

    logic signed [ACC_W-1:0] r_acc;
    logic [7:0]              r_cnt;
    logic                    r_sat;
    logic                    r_err;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [1:0]              r_out_act;
    logic signed [ACC_W-1:0] r_out_sum;
    logic                    r_out_sat;
    logic                    r_out_err;

    logic                    w_fire;
    logic                    w_done;
    logic                    w_err_now;
    logic [7:0]              w_cnt_next;
    logic [5:0]              w_diff;
    logic signed [ACC_W-1:0] w_diff_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_clip;
    logic                    w_gt_hi;
    logic                    w_lt_lo;

    assign w_diff     = {1'b0, bus.pos_cnt} - {1'b0, bus.neg_cnt};
    assign w_diff_ext = {{(ACC_W-6){w_diff[5]}}, w_diff};

    sat_add_s #(.W(ACC_W)) u_add (
        .i_a    (r_acc),
        .i_b    (w_diff_ext),
        .o_sum  (w_sum),
        .o_clip (w_clip)
    );

    // Handshake decode, overflow detection and next-state selection
    always_comb begin
        w_next_state = r_state;
        w_fire       = bus.in_valid & r_in_ready;
        w_done       = r_out_valid & bus.out_ready;
        w_err_now    = w_fire & (r_cnt >= MAX_B);
        w_cnt_next   = (r_cnt == 8'd255) ? r_cnt : (r_cnt + 8'd1);
        w_gt_hi      = (w_sum > bus.thr_hi);
        w_lt_lo      = (w_sum < bus.thr_lo);
        case (r_state)
            IDLE, ACCUM: begin
                if (w_fire) begin
                    w_next_state = bus.in_last ? HOLD : ACCUM;
                end else begin
                    w_next_state = r_state;
                end
            end
            HOLD: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accumulator, sticky flags and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= 8'd0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_act   <= ACT_ZERO;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state != HOLD);
            if (w_done) begin
                r_acc       <= '0;
                r_cnt       <= 8'd0;
                r_sat       <= 1'b0;
                r_err       <= 1'b0;
                r_out_valid <= 1'b0;
            end else if (w_fire) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_next;
                r_sat <= r_sat | w_clip;
                r_err <= r_err | w_err_now;
                if (bus.in_last) begin
                    r_out_valid <= 1'b1;
                    r_out_sum   <= w_sum;
                    r_out_act   <= act_encode(w_gt_hi, w_lt_lo);
                    r_out_sat   <= r_sat | w_clip;
                    r_out_err   <= r_err | w_err_now;
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_act   = r_out_act;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Directed bench: three accumulator instances (default, ACC_W=7, MAX_BEATS=2)
// share one stimulus bus; sel steers in_valid and picks whose outputs are checked.
module tb_ternary_neuron_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              v;
    logic [4:0]        pos;
    logic [4:0]        neg;
    logic              last;
    logic              out_ready;
    logic signed [9:0] thr_hi;
    logic signed [9:0] thr_lo;
    int                sel;

    int n_cmp = 0;
    int n_bad = 0;

    ternary_neuron_acc_if #(.ACC_W(10)) bus_a ();
    ternary_neuron_acc_if #(.ACC_W(7))  bus_b ();
    ternary_neuron_acc_if #(.ACC_W(10)) bus_c ();

    ternary_neuron_acc #(.ACC_W(10), .MAX_BEATS(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ternary_neuron_acc #(.ACC_W(7),  .MAX_BEATS(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    ternary_neuron_acc #(.ACC_W(10), .MAX_BEATS(2))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.in_valid  = v && (sel == 0);
    assign bus_b.in_valid  = v && (sel == 1);
    assign bus_c.in_valid  = v && (sel == 2);
    assign bus_a.pos_cnt   = pos;
    assign bus_b.pos_cnt   = pos;
    assign bus_c.pos_cnt   = pos;
    assign bus_a.neg_cnt   = neg;
    assign bus_b.neg_cnt   = neg;
    assign bus_c.neg_cnt   = neg;
    assign bus_a.in_last   = last;
    assign bus_b.in_last   = last;
    assign bus_c.in_last   = last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;
    assign bus_c.out_ready = out_ready;
    assign bus_a.thr_hi    = thr_hi;
    assign bus_c.thr_hi    = thr_hi;
    assign bus_b.thr_hi    = thr_hi[6:0];
    assign bus_a.thr_lo    = thr_lo;
    assign bus_c.thr_lo    = thr_lo;
    assign bus_b.thr_lo    = thr_lo[6:0];

    logic              o_ready;
    logic              o_valid;
    logic [1:0]        o_act;
    logic signed [9:0] o_sum;
    logic              o_sat;
    logic              o_err;

    always_comb begin
        o_ready = bus_a.in_ready;
        o_valid = bus_a.out_valid;
        o_act   = bus_a.out_act;
        o_sum   = bus_a.out_sum;
        o_sat   = bus_a.out_sat;
        o_err   = bus_a.out_err;
        if (sel == 1) begin
            o_ready = bus_b.in_ready;
            o_valid = bus_b.out_valid;
            o_act   = bus_b.out_act;
            o_sum   = {{3{bus_b.out_sum[6]}}, bus_b.out_sum};
            o_sat   = bus_b.out_sat;
            o_err   = bus_b.out_err;
        end else if (sel == 2) begin
            o_ready = bus_c.in_ready;
            o_valid = bus_c.out_valid;
            o_act   = bus_c.out_act;
            o_sum   = bus_c.out_sum;
            o_sat   = bus_c.out_sat;
            o_err   = bus_c.out_err;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int vld, input int sum,
                           input int act, input int sat, input int err);
        chk({tag, "_valid"}, int'(o_valid), vld);
        chk({tag, "_sum"},   int'(o_sum),   sum);
        chk({tag, "_act"},   int'(o_act),   act);
        chk({tag, "_sat"},   int'(o_sat),   sat);
        chk({tag, "_err"},   int'(o_err),   err);
    endtask

    // Present one beat, wait (bounded) for in_ready, return #1 after the accepting edge
    task automatic beat(input logic [4:0] p, input logic [4:0] n, input logic l);
        int k;
        @(negedge clk);
        v = 1'b1; pos = p; neg = n; last = l;
        k = 0;
        while (!o_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("ready_wait_timeout", int'(o_ready), 1);
        @(posedge clk); #1;
        v = 1'b0; last = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_valid_drop", int'(o_valid), 0);
        chk("hs_ready_rise", int'(o_ready), 1);
    endtask

    initial begin
        rst = 1'b1; v = 1'b0; pos = 5'd0; neg = 5'd0; last = 1'b0;
        out_ready = 1'b0; sel = 0; thr_hi = 10'sd3; thr_lo = -10'sd3;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset_in_ready", int'(o_ready), 1);
        @(negedge clk); rst = 1'b0;

        // single beat 20-5 = 15 > 3
        beat(5'd20, 5'd5, 1'b1);
        chk_out("single", 1, 15, 1, 0, 0);
        chk("single_hold_ready", int'(o_ready), 0);
        handshake();

        // three beats -7, -27, +3 = -31; held under back-pressure
        beat(5'd2, 5'd9, 1'b0);
        chk("three_accum_ready", int'(o_ready), 1);
        chk("three_no_valid", int'(o_valid), 0);
        beat(5'd0, 5'd27, 1'b0);
        beat(5'd4, 5'd1, 1'b1);
        chk_out("three", 1, -31, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_out("three_hold", 1, -31, 3, 0, 0);
        end
        handshake();

        // inverted thresholds: 0 > -5 and 0 < 5, +1 wins
        thr_hi = -10'sd5; thr_lo = 10'sd5;
        beat(5'd0, 5'd0, 1'b1);
        chk_out("prio", 1, 0, 1, 0, 0);
        handshake();
        thr_hi = 10'sd3; thr_lo = -10'sd3;

        // in_valid held during HOLD must not be absorbed
        beat(5'd7, 5'd0, 1'b1);
        chk_out("bp_first", 1, 7, 1, 0, 0);
        @(negedge clk);
        v = 1'b1; pos = 5'd31; neg = 5'd0; last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ready", int'(o_ready), 0);
            chk("bp_hold_sum", int'(o_sum), 7);
        end
        v = 1'b0; last = 1'b0;
        handshake();
        beat(5'd1, 5'd0, 1'b1);
        chk_out("bp_next", 1, 1, 0, 0, 0);
        handshake();

        // reset after 2 of 4 beats discards the partial evaluation
        beat(5'd5, 5'd0, 1'b0);
        beat(5'd5, 5'd0, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_valid", int'(o_valid), 0);
            chk("rst_ready", int'(o_ready), 1);
        end
        beat(5'd3, 5'd3, 1'b1);
        chk_out("rst_fresh", 1, 0, 0, 0, 0);
        handshake();

        // ACC_W = 7: 5 x 31 = 155 clips to 63
        sel = 1;
        for (int i = 0; i < 4; i++) beat(5'd31, 5'd0, 1'b0);
        beat(5'd31, 5'd0, 1'b1);
        chk_out("sat", 1, 63, 1, 1, 0);
        handshake();
        beat(5'd1, 5'd1, 1'b1);
        chk_out("sat_next", 1, 0, 0, 0, 0);
        handshake();

        // MAX_BEATS = 2: two beats legal, third sets err
        sel = 2;
        beat(5'd1, 5'd0, 1'b0);
        beat(5'd1, 5'd0, 1'b1);
        chk_out("max_ok", 1, 2, 0, 0, 0);
        handshake();
        beat(5'd1, 5'd0, 1'b0);
        beat(5'd1, 5'd0, 1'b0);
        beat(5'd1, 5'd0, 1'b1);
        chk("ovf_valid", int'(o_valid), 1);
        chk("ovf_err", int'(o_err), 1);
        chk("ovf_sum", int'(o_sum), 3);
        handshake();
        beat(5'd2, 5'd0, 1'b1);
        chk_out("ovf_next", 1, 2, 0, 0, 0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
